// File: rtl/i2c_ball_slave_if.sv
// Open-drain I2C bus seen by the ball hand-off slave: bus levels in, SDA pull-down enable out.
interface i2c_ball_slave_if;
  logic i_scl;
  logic i_sda;
  logic o_sda_oe;

  modport master (output i_scl, output i_sda, input  o_sda_oe);
  modport slave  (input  i_scl, input  i_sda, output o_sda_oe);
endinterface

// File: rtl/i2c_ball_slave.sv
// I2C write-only slave that receives the 6-byte ball packet and commits it atomically on STOP.
// Optional I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter on both synchronised lines.
module i2c_ball_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  i2c_ball_slave_if.slave  bus,
  output logic [7:0]       slv_reg0_y0,
  output logic [7:0]       slv_reg1_y1,
  output logic [7:0]       slv_reg2_Yspeed,
  output logic [7:0]       slv_reg3_gravity,
  output logic [7:0]       slv_reg4_ballspeed,
  output logic [7:0]       slv_reg5_win_flag,
  output logic             is_slave_done,
  output logic             responsing_i2c
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
  } state_t;

  // Synchronisers reset to 1 so an idle (pulled-up) bus produces no edge after reset.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_f, sda_f, scl_prev, sda_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.i_scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.i_sda};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_win, sda_win;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_win <= '1;
      sda_win <= '1;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
    end else begin
      scl_win <= {scl_win[0], scl_sync[SYNC_STAGES-1]};
      sda_win <= {sda_win[0], sda_sync[SYNC_STAGES-1]};
      scl_f   <= maj3(scl_sync[SYNC_STAGES-1], scl_win[0], scl_win[1]);
      sda_f   <= maj3(sda_sync[SYNC_STAGES-1], sda_win[0], sda_win[1]);
    end
  end
`else
  assign scl_f = scl_sync[SYNC_STAGES-1];
  assign sda_f = sda_sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_prev <= scl_f;
      sda_prev <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_f & ~scl_prev;
  assign scl_fall  = ~scl_f &  scl_prev;
  assign start_det =  scl_f & scl_prev &  sda_prev & ~sda_f;
  assign stop_det  =  scl_f & scl_prev & ~sda_prev &  sda_f;

  state_t     state, state_d;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic [2:0] byte_cnt, byte_cnt_d;
  logic [7:0] shift, shift_d;
  logic       shadow_we, commit;
  logic [7:0] shadow [6];
  logic [7:0] regs   [6];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    byte_cnt_d = byte_cnt;
    shift_d    = shift;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    if (start_det) begin
      state_d    = S_ADDR;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else if (stop_det) begin
      commit     = (byte_cnt == 3'd6);
      state_d    = S_IDLE;
      byte_cnt_d = '0;
    end else begin
      unique case (state)
        S_ADDR, S_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shift_d   = {shift[6:0], sda_f};
            bit_cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_d = '0;
            if (state == S_ADDR) begin
              // Read requests and foreign addresses are both NACKed.
              state_d = (shift == {SLAVE_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
            end else if (byte_cnt != 3'd6) begin
              shadow_we  = 1'b1;
              byte_cnt_d = byte_cnt + 3'd1;
              state_d    = S_DATA_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR_ACK, S_DATA_ACK: if (scl_fall) state_d = S_DATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      shift         <= '0;
      is_slave_done <= 1'b0;
      // NOTE: the shadow array is reset too, so a packet can never expose stale bytes from before reset.
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= '0;
        regs[i]   <= '0;
      end
    end else begin
      bit_cnt       <= bit_cnt_d;
      byte_cnt      <= byte_cnt_d;
      shift         <= shift_d;
      is_slave_done <= commit;
      if (shadow_we) shadow[byte_cnt] <= shift;
      if (commit) begin
        for (int i = 0; i < 6; i++) regs[i] <= shadow[i];
      end
    end
  end

  // Driven straight from the state register so a START or reset releases SDA without delay.
  assign bus.o_sda_oe = (state == S_ADDR_ACK) || (state == S_DATA_ACK);
  assign responsing_i2c = (state != S_IDLE);

  assign slv_reg0_y0        = regs[0];
  assign slv_reg1_y1        = regs[1];
  assign slv_reg2_Yspeed    = regs[2];
  assign slv_reg3_gravity   = regs[3];
  assign slv_reg4_ballspeed = regs[4];
  assign slv_reg5_win_flag  = regs[5];

endmodule

// File: tb/tb_i2c_ball_slave.sv
// Bench for i2c_ball_slave: bus-level master tasks plus a packet-level model of ACKs and committed registers.
module tb_i2c_ball_slave;
  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic [7:0] dut_regs [6];
  logic done, busy;

  always #5 clk = ~clk;

  i2c_ball_slave_if bus();
  assign bus.i_scl = m_scl;
  assign bus.i_sda = m_sda & ~bus.o_sda_oe;  // wired-AND open-drain bus

  i2c_ball_slave dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus),
    .slv_reg0_y0        (dut_regs[0]),
    .slv_reg1_y1        (dut_regs[1]),
    .slv_reg2_Yspeed    (dut_regs[2]),
    .slv_reg3_gravity   (dut_regs[3]),
    .slv_reg4_ballspeed (dut_regs[4]),
    .slv_reg5_win_flag  (dut_regs[5]),
    .is_slave_done      (done),
    .responsing_i2c     (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Packet-level model: bytes accepted since the last START, and the registers the game should see.
  logic [7:0] exp_regs  [6];
  logic [7:0] pend_regs [6];
  bit         pending;
  bit         addressed;
  bit         first_byte;
  int         done_cnt;
  logic [7:0] data_q [$];

  // Compare process: committed registers and the done pulse, every cycle out of reset.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        if (done) begin
          done_cnt++;
          check("done_pulse_expected", 32'(pending), 32'd1);
          if (pending) begin
            for (int i = 0; i < 6; i++) exp_regs[i] = pend_regs[i];
            pending = 1'b0;
          end
        end
        for (int i = 0; i < 6; i++) check($sformatf("slv_reg%0d", i), dut_regs[i], exp_regs[i]);
      end
    end
  end

  task automatic q_wait(input int n = 1);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic model_clear();
    data_q.delete();
    addressed  = 1'b0;
    first_byte = 1'b1;
  endtask

  task automatic m_start();
    if (!m_scl) begin
      m_sda = 1'b1; q_wait();
      m_scl = 1'b1; q_wait();
    end
    m_sda = 1'b0; q_wait();
    m_scl = 1'b0; q_wait();
    model_clear();
  endtask

  task automatic m_write(input logic [7:0] b);
    logic exp_ack, got_ack;
    exp_ack = first_byte ? (b == 8'h84) : (addressed && data_q.size() < 6);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; q_wait();
      m_scl = 1'b1; q_wait(2);
      m_scl = 1'b0; q_wait();
    end
    m_sda = 1'b1; q_wait();
    m_scl = 1'b1; q_wait();
    got_ack = ~bus.i_sda;
    check("busy_in_txn", 32'(busy), 32'd1);
    q_wait();
    m_scl = 1'b0; q_wait();
    check($sformatf("ack_byte_%02h", b), 32'(got_ack), 32'(exp_ack));
    if (first_byte) begin
      addressed  = exp_ack;
      first_byte = 1'b0;
    end else if (exp_ack) begin
      data_q.push_back(b);
    end
  endtask

  task automatic m_stop();
    bit exp_commit;
    exp_commit = addressed && (data_q.size() == 6);
    m_sda = 1'b0; q_wait();
    m_scl = 1'b1; q_wait();
    if (exp_commit) begin
      for (int i = 0; i < 6; i++) pend_regs[i] = data_q[i];
      pending = 1'b1;
    end
    m_sda = 1'b1;
    repeat (20) @(negedge clk);
    if (exp_commit) check("commit_pulse_seen", 32'(pending), 32'd0);
    pending = 1'b0;
    check("busy_after_stop", 32'(busy), 32'd0);
    model_clear();
  endtask

  task automatic packet(input logic [7:0] addr, input logic [7:0] bytes [$]);
    m_start();
    m_write(addr);
    foreach (bytes[i]) m_write(bytes[i]);
    m_stop();
  endtask

  logic [7:0] pkt [$];
  bit         saw_busy;
  int         waited;
  int         done_before;

  initial begin
    for (int i = 0; i < 6; i++) begin exp_regs[i] = '0; pend_regs[i] = '0; end
    pending = 1'b0; done_cnt = 0;
    model_clear();
    repeat (4) @(negedge clk);
    #1;
    check("reset_sda_oe", 32'(bus.o_sda_oe), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_reg0", dut_regs[0], 32'h00);
    @(negedge clk);
    reset = 1'b1;
    q_wait(2);

    // Full packet commits once.
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    packet(8'h84, pkt);
    check("t2_reg0_lit", dut_regs[0], 32'h11);
    check("t2_reg5_lit", dut_regs[5], 32'h66);
    check("t2_pulses", done_cnt, 1);

    // Wrong address: everything NACKed, outputs hold.
    pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    packet(8'h86, pkt);
    check("t3_reg2_lit", dut_regs[2], 32'h33);
    check("t3_pulses", done_cnt, 1);

    // Repeated START discards the partial packet.
    m_start();
    m_write(8'h84); m_write(8'hAA); m_write(8'hBB); m_write(8'hBB);
    m_start();
    m_write(8'h84);
    for (int i = 1; i <= 6; i++) m_write(8'(i));
    m_stop();
    check("t4_reg0_lit", dut_regs[0], 32'h01);
    check("t4_reg5_lit", dut_regs[5], 32'h06);
    check("t4_pulses", done_cnt, 2);

    // Seventh byte NACKed, first six committed.
    pkt = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    packet(8'h84, pkt);
    check("t5_reg0_lit", dut_regs[0], 32'h10);
    check("t5_reg5_lit", dut_regs[5], 32'h15);
    check("t5_pulses", done_cnt, 3);

    // Reset while the slave is driving the address ACK.
    m_start();
    for (int i = 7; i >= 0; i--) begin
      m_sda = (i == 7 || i == 2); q_wait();
      m_scl = 1'b1; q_wait(2);
      m_scl = 1'b0; @(negedge clk);
    end
    m_sda = 1'b1;
    waited = 0;
    while (!bus.o_sda_oe && waited < 40) begin @(negedge clk); waited++; end
    check("t1_oe_before_reset", 32'(bus.o_sda_oe), 32'd1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) exp_regs[i] = '0;
    pending = 1'b0;
    #1;
    check("t1_oe_released", 32'(bus.o_sda_oe), 32'd0);
    check("t1_reg1_cleared", dut_regs[1], 32'h00);
    check("t1_done_low", 32'(done), 32'd0);
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_clear();
    q_wait(2);

    // One-clock SDA spike while SCL is high and the bus is idle.
    done_before = done_cnt;
    saw_busy = 1'b0;
    m_sda = 1'b0; @(negedge clk);
    m_sda = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
`ifdef I2C_SLV_GLITCH_FILTER_EN
    check("t6_glitch_rejected", 32'(saw_busy), 32'd0);
`else
    check("t6_glitch_is_start", 32'(saw_busy), 32'd1);
`endif
    check("t6_no_pulse", done_cnt, done_before);

    // Randomised packets: address, length and repeated STARTs vary.
    for (int t = 0; t < 12; t++) begin
      logic [7:0] addr;
      int n;
      addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h84;
      m_start();
      m_write(addr);
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++) m_write(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        m_start();
        m_write(8'h84);
        n = $urandom_range(4, 7);
        for (int i = 0; i < n; i++) m_write(8'($urandom));
      end
      m_stop();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
